placement_eval: RTL and testbench
=================================

Name: placement_eval

Overview:
- Downstream stage of the placer; scores a finished placement.
- Walks the edge lists (e_a/e_b) and reads the pos_X/pos_Y RAMs the placer filled.
- Computes the total wirelength cost, the longest edge, an unplaced-endpoint count and an overlap flag.
- The placer releases start when it finishes; results feed the top-level report/`out` logic.

Parameters:
- N_EDGE, 15, number of edges walked (0 allowed).
- ADDR_W, 4, address width of edge and position memories.
- DATA_W, 32, signed data width of all memory words and results.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse on DONE entry.
- edge_re  out  1  read enable, shared by the e_a and e_b ROMs.
- edge_addr  out  ADDR_W  edge index.
- ea_data  in  DATA_W  e_a[edge_addr], valid 1 cycle after edge_re.
- eb_data  in  DATA_W  e_b[edge_addr], valid 1 cycle after edge_re.
- pos_re  out  1  read enable, shared by the pos_X and pos_Y RAMs.
- pos_addr  out  ADDR_W  node index.
- pos_x  in  DATA_W  pos_X[pos_addr], 1-cycle latency.
- pos_y  in  DATA_W  pos_Y[pos_addr], 1-cycle latency.
- total_cost  out  DATA_W  sum of (len-1) over scored edges.
- max_len  out  DATA_W  largest len seen.
- unplaced_cnt  out  DATA_W  edges skipped because an endpoint is unplaced.
- overlap  out  1  two distinct nodes share a cell.

Behaviour:
- Reset: state IDLE; busy=0, done=0, edge_re=0, pos_re=0, addresses 0, total_cost=0, max_len=0, unplaced_cnt=0, overlap=0.
- Reset mid-run aborts and returns to IDLE with the same values.
- FSM states: IDLE, RD_EDGE, RD_A, RD_B, ACC, DONE.
- IDLE/DONE with start=1:
  - clear all results;
  - i=0;
  - go to RD_EDGE; if N_EDGE==0, go to DONE directly.
- RD_EDGE: edge_re=1, edge_addr=i.
- RD_A:
  - latch a=ea_data, b=eb_data;
  - pos_re=1, pos_addr=ea_data.
- RD_B:
  - latch xa=pos_x, ya=pos_y;
  - pos_re=1, pos_addr=b.
- ACC: xb=pos_x, yb=pos_y, then:
  - If any coordinate == -1: unplaced_cnt += 1; no cost added.
  - Else len = |xa-xb| + |ya-yb|, in signed DATA_W.
  - Self-loop (a==b): contributes 0 and is not an overlap.
  - Else if len==0: overlap=1 (sticky), contributes 0.
  - Else: total_cost += len-1, saturating at 2^(DATA_W-1)-1; max_len = max(max_len, len).
  - Then i += 1; go to RD_EDGE if i<N_EDGE, else DONE.
- Timing: 4 cycles per edge; done asserts 4*N_EDGE+1 cycles after the start-accept edge.
- Enables (edge_re, pos_re) are high only in their issuing state; deasserted otherwise.
- DONE: done=1 for exactly one cycle; results hold until the next accepted start or reset; the state remains DONE.
- start while busy is ignored.

Optional Feature:
- PLACEMENT_EVAL_HIST_EN defined:
  - Adds input hist_sel[2:0] and output hist_cnt[DATA_W-1:0].
  - Maintains 8 counters of scored-edge len, bins 0..7; len>=7 goes to bin 7.
  - Counters clear on start/reset; hist_cnt = bin[hist_sel], combinational read.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- placement_pkg holds:
  - UNPLACED = -1;
  - default DATA_W/ADDR_W;
  - state encoding localparams shared with the placer;
  - HIST_BINS = 8.
- One combinational sub-module, manhattan_len: inputs xa, ya, xb, yb; outputs len and any_unplaced. Reused by the placer for its own checks.

Test Plan:
- 3 edges (0-1, 1-2, 2-3), positions (0,0), (0,1), (1,1), (3,1) -> total_cost=1, max_len=2, unplaced_cnt=0, overlap=0, done at cycle 13.
- Node 2 at (-1,-1), edges 0-1, 1-2 -> unplaced_cnt=1, total_cost=0, max_len=1.
- Nodes 0 and 1 both at (2,2), edge 0-1, plus self-loop 3-3 -> overlap=1, total_cost=0.
- N_EDGE=0, start -> done pulses 1 cycle after accept; all results 0.
- Reset asserted during RD_B of edge 5 -> next cycle IDLE, all outputs 0; a fresh start reproduces the full-run result.
- PLACEMENT_EVAL_HIST_EN, lens {1,1,2,9} -> hist_cnt at sel 1/2/7 = 2/1/1; a start pulse during busy changes nothing.

Source files
------------

// File: rtl/placement_pkg.sv
// Shared constants, FSM encoding and helpers for the placement evaluator and the placer.
package placement_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int UNPLACED   = -1;
    localparam int HIST_BINS  = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_EDGE = 3'd1;
    localparam logic [2:0] ST_RD_A    = 3'd2;
    localparam logic [2:0] ST_RD_B    = 3'd3;
    localparam logic [2:0] ST_ACC     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD_EDGE = ST_RD_EDGE,
        S_RD_A    = ST_RD_A,
        S_RD_B    = ST_RD_B,
        S_ACC     = ST_ACC,
        S_DONE    = ST_DONE
    } eval_state_e;

    // Lengths of 7 and above share the last histogram bin.
    function automatic logic [2:0] hist_bin(input int len);
        if (len >= 7) begin
            return 3'd7;
        end else begin
            return 3'(len);
        end
    endfunction

endpackage

// File: rtl/placement_eval_if.sv
// Read-side bus between the evaluator (master) and the edge/position memories (slave).
interface placement_eval_if
    import placement_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                     edge_re;
    logic [ADDR_W-1:0]        edge_addr;
    logic signed [DATA_W-1:0] ea_data;
    logic signed [DATA_W-1:0] eb_data;
    logic                     pos_re;
    logic [ADDR_W-1:0]        pos_addr;
    logic signed [DATA_W-1:0] pos_x;
    logic signed [DATA_W-1:0] pos_y;

    modport master (
        output edge_re, edge_addr, pos_re, pos_addr,
        input  ea_data, eb_data, pos_x, pos_y
    );

    modport slave (
        input  edge_re, edge_addr, pos_re, pos_addr,
        output ea_data, eb_data, pos_x, pos_y
    );
endinterface

// File: rtl/manhattan_len.sv
// Manhattan distance between two cells, flagging any unplaced (-1) coordinate.
module manhattan_len
    import placement_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] xa_i,
    input  logic signed [DATA_W-1:0] ya_i,
    input  logic signed [DATA_W-1:0] xb_i,
    input  logic signed [DATA_W-1:0] yb_i,
    output logic signed [DATA_W-1:0] len_o,
    output logic                     any_unplaced_o
);
    localparam logic signed [DATA_W-1:0] UNP = DATA_W'(UNPLACED);

    logic signed [DATA_W-1:0] dx_s;
    logic signed [DATA_W-1:0] dy_s;

    // Absolute differences summed; the caller decides whether the result is meaningful.
    always_comb begin
        dx_s = xa_i - xb_i;
        dy_s = ya_i - yb_i;
        if (dx_s < 0) begin
            dx_s = -dx_s;
        end else begin
            dx_s = dx_s;
        end
        if (dy_s < 0) begin
            dy_s = -dy_s;
        end else begin
            dy_s = dy_s;
        end
        len_o          = dx_s + dy_s;
        any_unplaced_o = (xa_i == UNP) || (ya_i == UNP) || (xb_i == UNP) || (yb_i == UNP);
    end
endmodule

// File: rtl/placement_eval.sv
// Scores a finished placement: wirelength cost, longest edge, unplaced count, overlap.
// Optional length histogram enabled by defining PLACEMENT_EVAL_HIST_EN.
module placement_eval
    import placement_pkg::*;
#(
    parameter int N_EDGE = 15,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    placement_eval_if.master         mem,
    output logic signed [DATA_W-1:0] total_cost,
    output logic signed [DATA_W-1:0] max_len,
    output logic signed [DATA_W-1:0] unplaced_cnt,
    output logic                     overlap
`ifdef PLACEMENT_EVAL_HIST_EN
    ,
    input  logic [2:0]               hist_sel,
    output logic [DATA_W-1:0]        hist_cnt
`endif
);
    localparam logic [ADDR_W:0] N_EDGE_W = (ADDR_W+1)'(N_EDGE);
    localparam logic [ADDR_W:0] ONE_I    = (ADDR_W+1)'(1);
    localparam logic signed [DATA_W-1:0] COST_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    eval_state_e              state_q;
    logic [ADDR_W:0]          i_q;
    logic [ADDR_W:0]          i_next_s;
    logic signed [DATA_W-1:0] a_q, b_q, xa_q, ya_q;
    logic signed [DATA_W-1:0] total_cost_q, max_len_q, unplaced_q;
    logic                     overlap_q, busy_q, done_q, edge_re_q;
    logic [ADDR_W-1:0]        edge_addr_q;
    logic signed [DATA_W-1:0] len_s;
    logic                     unp_s, scored_s, accept_s;
    logic [DATA_W:0]          sum_wide_s;
    logic signed [DATA_W-1:0] cost_d;

    manhattan_len #(.DATA_W(DATA_W)) u_len (
        .xa_i           (xa_q),
        .ya_i           (ya_q),
        .xb_i           (mem.pos_x),
        .yb_i           (mem.pos_y),
        .len_o          (len_s),
        .any_unplaced_o (unp_s)
    );

    // Edge scoring decision and saturating cost update; len-1 is never negative for a scored edge.
    always_comb begin
        i_next_s   = i_q + ONE_I;
        accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        scored_s   = !unp_s && (a_q != b_q) && (len_s != '0);
        sum_wide_s = {total_cost_q[DATA_W-1], total_cost_q} + {len_s[DATA_W-1], len_s}
                   - {{DATA_W{1'b0}}, 1'b1};
        if (sum_wide_s > {1'b0, COST_MAX}) begin
            cost_d = COST_MAX;
        end else begin
            cost_d = sum_wide_s[DATA_W-1:0];
        end
    end

    // Position reads are issued combinationally because RD_A addresses with the word just returned.
    always_comb begin
        mem.pos_re   = 1'b0;
        mem.pos_addr = '0;
        case (state_q)
            S_RD_A: begin
                mem.pos_re   = 1'b1;
                mem.pos_addr = mem.ea_data[ADDR_W-1:0];
            end
            S_RD_B: begin
                mem.pos_re   = 1'b1;
                mem.pos_addr = b_q[ADDR_W-1:0];
            end
            default: begin
                mem.pos_re   = 1'b0;
                mem.pos_addr = '0;
            end
        endcase
    end

    // Evaluation FSM with registered status, edge-read and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            xa_q         <= '0;
            ya_q         <= '0;
            total_cost_q <= '0;
            max_len_q    <= '0;
            unplaced_q   <= '0;
            overlap_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            edge_re_q    <= 1'b0;
            edge_addr_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            edge_re_q   <= 1'b0;
            edge_addr_q <= '0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        total_cost_q <= '0;
                        max_len_q    <= '0;
                        unplaced_q   <= '0;
                        overlap_q    <= 1'b0;
                        i_q          <= '0;
                        if (N_EDGE_W == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_RD_EDGE;
                            busy_q    <= 1'b1;
                            edge_re_q <= 1'b1;
                        end
                    end
                end
                S_RD_EDGE: state_q <= S_RD_A;
                S_RD_A: begin
                    a_q     <= mem.ea_data;
                    b_q     <= mem.eb_data;
                    state_q <= S_RD_B;
                end
                S_RD_B: begin
                    xa_q    <= mem.pos_x;
                    ya_q    <= mem.pos_y;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    if (unp_s) begin
                        unplaced_q <= unplaced_q + DATA_W'(1);
                    end else if (a_q != b_q) begin
                        if (len_s == '0) begin
                            overlap_q <= 1'b1;
                        end else begin
                            total_cost_q <= cost_d;
                            if (len_s > max_len_q) begin
                                max_len_q <= len_s;
                            end
                        end
                    end
                    i_q <= i_next_s;
                    if (i_next_s < N_EDGE_W) begin
                        state_q     <= S_RD_EDGE;
                        edge_re_q   <= 1'b1;
                        edge_addr_q <= i_next_s[ADDR_W-1:0];
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem.edge_re   = edge_re_q;
    assign mem.edge_addr = edge_addr_q;
    assign total_cost    = total_cost_q;
    assign max_len       = max_len_q;
    assign unplaced_cnt  = unplaced_q;
    assign overlap       = overlap_q;

`ifdef PLACEMENT_EVAL_HIST_EN
    logic [DATA_W-1:0] hist_q [HIST_BINS];

    // Length histogram of scored edges, cleared together with the other results.
    always_ff @(posedge clk) begin
        if (reset || accept_s) begin
            for (int k = 0; k < HIST_BINS; k++) begin
                hist_q[k] <= '0;
            end
        end else if ((state_q == S_ACC) && scored_s) begin
            hist_q[hist_bin(int'(len_s))] <= hist_q[hist_bin(int'(len_s))] + DATA_W'(1);
        end
    end

    assign hist_cnt = hist_q[hist_sel];
`endif
endmodule

// File: tb/tb_placement_eval.sv
// Directed bench for placement_eval: three instances (3, 0 and 8 edges) over shared memory contents.
module tb_placement_eval;
    import placement_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start3 = 1'b0, start0 = 1'b0, start8 = 1'b0;
    logic busy3, done3, ov3, busy0, done0, ov0, busy8, done8, ov8;
    logic signed [DW-1:0] tc3, ml3, uc3, tc0, ml0, uc0, tc8, ml8, uc8;
`ifdef PLACEMENT_EVAL_HIST_EN
    logic [2:0]    hs3 = 3'd0, hs0 = 3'd0, hs8 = 3'd0;
    logic [DW-1:0] hc3, hc0, hc8;
`endif

    logic signed [DW-1:0] e_a [16];
    logic signed [DW-1:0] e_b [16];
    logic signed [DW-1:0] px  [16];
    logic signed [DW-1:0] py  [16];

    int total = 0;
    int bad   = 0;

    placement_eval_if #(.ADDR_W(AW), .DATA_W(DW)) m3 ();
    placement_eval_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
    placement_eval_if #(.ADDR_W(AW), .DATA_W(DW)) m8 ();

    // One-cycle-latency memory responders, one per instance.
    always @(posedge clk) begin
        if (m3.edge_re) begin m3.ea_data <= e_a[m3.edge_addr]; m3.eb_data <= e_b[m3.edge_addr]; end
        if (m3.pos_re)  begin m3.pos_x <= px[m3.pos_addr]; m3.pos_y <= py[m3.pos_addr]; end
        if (m0.edge_re) begin m0.ea_data <= e_a[m0.edge_addr]; m0.eb_data <= e_b[m0.edge_addr]; end
        if (m0.pos_re)  begin m0.pos_x <= px[m0.pos_addr]; m0.pos_y <= py[m0.pos_addr]; end
        if (m8.edge_re) begin m8.ea_data <= e_a[m8.edge_addr]; m8.eb_data <= e_b[m8.edge_addr]; end
        if (m8.pos_re)  begin m8.pos_x <= px[m8.pos_addr]; m8.pos_y <= py[m8.pos_addr]; end
    end

    placement_eval #(.N_EDGE(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
        .clk(clk), .reset(rst), .start(start3), .busy(busy3), .done(done3), .mem(m3),
        .total_cost(tc3), .max_len(ml3), .unplaced_cnt(uc3), .overlap(ov3)
`ifdef PLACEMENT_EVAL_HIST_EN
        , .hist_sel(hs3), .hist_cnt(hc3)
`endif
    );

    placement_eval #(.N_EDGE(0), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
        .clk(clk), .reset(rst), .start(start0), .busy(busy0), .done(done0), .mem(m0),
        .total_cost(tc0), .max_len(ml0), .unplaced_cnt(uc0), .overlap(ov0)
`ifdef PLACEMENT_EVAL_HIST_EN
        , .hist_sel(hs0), .hist_cnt(hc0)
`endif
    );

    placement_eval #(.N_EDGE(8), .ADDR_W(AW), .DATA_W(DW)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .busy(busy8), .done(done8), .mem(m8),
        .total_cost(tc8), .max_len(ml8), .unplaced_cnt(uc8), .overlap(ov8)
`ifdef PLACEMENT_EVAL_HIST_EN
        , .hist_sel(hs8), .hist_cnt(hc8)
`endif
    );

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) begin
            e_a[k] = 32'sd15; e_b[k] = 32'sd15;
            px[k]  = 32'sd20 + k; py[k] = 32'sd30;
        end
    endtask

    task automatic set_node(input int k, input int x, input int y);
        px[k] = x; py[k] = y;
    endtask

    task automatic set_edge(input int i, input int a, input int b);
        e_a[i] = a; e_b[i] = b;
    endtask

    // Start the 3-edge instance and wait for done; cycle 1 is the one after the accept edge.
    task automatic run3(output int done_cyc, output logic busy1, output logic ere1,
                        output logic pre6, output int pa6);
        int cyc;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        cyc = 1; done_cyc = -1; busy1 = busy3; ere1 = m3.edge_re; pre6 = 1'b0; pa6 = -1;
        while (cyc < 200 && done_cyc < 0) begin
            if (cyc == 6) begin pre6 = m3.pos_re; pa6 = int'(m3.pos_addr); end
            if (done3) done_cyc = cyc;
            else begin @(negedge clk); cyc++; end
        end
    endtask

    // Start the 8-edge instance, optionally pulsing start again at cycle poke_cyc.
    task automatic run8(input int poke_cyc, output int done_cyc);
        int cyc;
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        cyc = 1; done_cyc = -1;
        while (cyc < 200 && done_cyc < 0) begin
            if (done8) done_cyc = cyc;
            else begin
                start8 = (cyc == poke_cyc);
                @(negedge clk); cyc++;
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy3); end
        total++; if (done3 !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done3); end
        total++; if (m3.edge_re !== 1'b0 || m3.pos_re !== 1'b0) begin bad++; $display("FAIL reset_re got=%0b%0b want=00", m3.edge_re, m3.pos_re); end
        total++; if (m3.edge_addr !== 4'd0 || m3.pos_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d/%0d want=0/0", m3.edge_addr, m3.pos_addr); end
        total++; if (tc3 !== 32'sd0 || ml3 !== 32'sd0 || uc3 !== 32'sd0 || ov3 !== 1'b0) begin bad++; $display("FAIL reset_results got=%0d/%0d/%0d/%0b want=0/0/0/0", tc3, ml3, uc3, ov3); end
        rst = 1'b0;
    endtask

    task automatic test_overlap();
        int dc; logic b1, e1, p6; int a6;
        clear_mem();
        set_node(0, 2, 2); set_node(1, 2, 2); set_node(3, 5, 5);
        set_edge(0, 0, 1); set_edge(1, 3, 3); set_edge(2, 3, 3);
        run3(dc, b1, e1, p6, a6);
        total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL overlap_flag got=%0b want=1", ov3); end
        total++; if (tc3 !== 32'sd0 || ml3 !== 32'sd0 || uc3 !== 32'sd0) begin bad++; $display("FAIL overlap_results got=%0d/%0d/%0d want=0/0/0", tc3, ml3, uc3); end
    endtask

    task automatic test_unplaced();
        int dc; logic b1, e1, p6; int a6;
        clear_mem();
        set_node(0, 0, 0); set_node(1, 0, 1); set_node(2, -1, -1);
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 0, 0);
        run3(dc, b1, e1, p6, a6);
        total++; if (uc3 !== 32'sd1) begin bad++; $display("FAIL unplaced_cnt got=%0d want=1", uc3); end
        total++; if (tc3 !== 32'sd0 || ml3 !== 32'sd1) begin bad++; $display("FAIL unplaced_cost got=%0d/%0d want=0/1", tc3, ml3); end
        total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL unplaced_overlap_cleared got=%0b want=0", ov3); end
    endtask

    task automatic test_basic();
        int dc; logic b1, e1, p6; int a6;
        clear_mem();
        set_node(0, 0, 0); set_node(1, 0, 1); set_node(2, 1, 1); set_node(3, 3, 1);
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 2, 3);
        run3(dc, b1, e1, p6, a6);
        total++; if (dc !== 13) begin bad++; $display("FAIL basic_done_cycle got=%0d want=13", dc); end
        total++; if (b1 !== 1'b1 || e1 !== 1'b1) begin bad++; $display("FAIL basic_cycle1 busy/edge_re got=%0b/%0b want=1/1", b1, e1); end
        total++; if (p6 !== 1'b1 || a6 !== 1) begin bad++; $display("FAIL basic_pos_read got=%0b@%0d want=1@1", p6, a6); end
        total++; if (tc3 !== 32'sd1 || ml3 !== 32'sd2) begin bad++; $display("FAIL basic_cost got=%0d/%0d want=1/2", tc3, ml3); end
        total++; if (uc3 !== 32'sd0 || ov3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL basic_flags got=%0d/%0b/%0b want=0/0/0", uc3, ov3, busy3); end
        @(negedge clk);
        total++; if (done3 !== 1'b0 || tc3 !== 32'sd1) begin bad++; $display("FAIL basic_done_pulse got=%0b/%0d want=0/1", done3, tc3); end
    endtask

    task automatic test_saturate();
        int dc; logic b1, e1, p6; int a6;
        clear_mem();
        set_node(0, 0, 0); set_node(1, 32'h4000_0000, 0);
        set_edge(0, 0, 1); set_edge(1, 1, 0); set_edge(2, 0, 1);
        run3(dc, b1, e1, p6, a6);
        total++; if (tc3 !== 32'sh7FFF_FFFF) begin bad++; $display("FAIL sat_cost got=%0h want=7fffffff", tc3); end
        total++; if (ml3 !== 32'sh4000_0000) begin bad++; $display("FAIL sat_max_len got=%0h want=40000000", ml3); end
    endtask

    task automatic test_zero_edges();
        int cyc;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        cyc = 1;
        while (cyc < 50 && done0 !== 1'b1) begin @(negedge clk); cyc++; end
        total++; if (cyc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", cyc); end
        total++; if (tc0 !== 32'sd0 || ml0 !== 32'sd0 || uc0 !== 32'sd0 || ov0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL zero_results got=%0d/%0d/%0d/%0b/%0b want=0", tc0, ml0, uc0, ov0, busy0); end
        @(negedge clk);
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%0b want=0", done0); end
    endtask

    task automatic setup8();
        clear_mem();
        for (int k = 0; k < 8; k++) begin set_node(k, k, 0); set_edge(k, k, k + 1); end
        set_node(8, 10, 0);
    endtask

    task automatic test_reset_midrun();
        int dc;
        setup8();
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (22) @(negedge clk);
        total++; if (busy8 !== 1'b1 || ml8 !== 32'sd1) begin bad++; $display("FAIL midrun_progress got=%0b/%0d want=1/1", busy8, ml8); end
        total++; if (m8.pos_re !== 1'b1 || m8.pos_addr !== 4'd6) begin bad++; $display("FAIL midrun_rdb got=%0b@%0d want=1@6", m8.pos_re, m8.pos_addr); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0 || m8.edge_re !== 1'b0 || m8.pos_re !== 1'b0) begin bad++; $display("FAIL midrun_reset_ctrl got=%0b%0b%0b%0b want=0000", busy8, done8, m8.edge_re, m8.pos_re); end
        total++; if (ml8 !== 32'sd0 || tc8 !== 32'sd0 || m8.pos_addr !== 4'd0) begin bad++; $display("FAIL midrun_reset_vals got=%0d/%0d/%0d want=0/0/0", ml8, tc8, m8.pos_addr); end
        rst = 1'b0;
        run8(10, dc);
        total++; if (dc !== 33) begin bad++; $display("FAIL rerun_done_cycle got=%0d want=33", dc); end
        total++; if (tc8 !== 32'sd2 || ml8 !== 32'sd3 || uc8 !== 32'sd0 || ov8 !== 1'b0) begin bad++; $display("FAIL rerun_results got=%0d/%0d/%0d/%0b want=2/3/0/0", tc8, ml8, uc8, ov8); end
    endtask

`ifdef PLACEMENT_EVAL_HIST_EN
    task automatic test_hist();
        int dc;
        clear_mem();
        set_node(0, 0, 0); set_node(1, 1, 0); set_node(2, 2, 0); set_node(3, 4, 0); set_node(4, 4, 9);
        set_node(5, 7, 7);
        set_edge(0, 0, 1); set_edge(1, 1, 2); set_edge(2, 2, 3); set_edge(3, 3, 4);
        for (int k = 4; k < 8; k++) set_edge(k, 5, 5);
        run8(10, dc);
        total++; if (dc !== 33 || tc8 !== 32'sd9 || ml8 !== 32'sd9) begin bad++; $display("FAIL hist_run got=%0d/%0d/%0d want=33/9/9", dc, tc8, ml8); end
        hs8 = 3'd1; #1;
        total++; if (hc8 !== 32'd2) begin bad++; $display("FAIL hist_bin1 got=%0d want=2", hc8); end
        hs8 = 3'd2; #1;
        total++; if (hc8 !== 32'd1) begin bad++; $display("FAIL hist_bin2 got=%0d want=1", hc8); end
        hs8 = 3'd7; #1;
        total++; if (hc8 !== 32'd1) begin bad++; $display("FAIL hist_bin7 got=%0d want=1", hc8); end
        hs8 = 3'd0; #1;
        total++; if (hc8 !== 32'd0) begin bad++; $display("FAIL hist_bin0 got=%0d want=0", hc8); end
    endtask
`endif

    initial begin
        clear_mem();
        test_reset();
        test_overlap();
        test_unplaced();
        test_basic();
        test_saturate();
        test_zero_edges();
        test_reset_midrun();
`ifdef PLACEMENT_EVAL_HIST_EN
        test_hist();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
